// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill/flush bundle between the pipeline control and the register scoreboard.
// The master drives the pipeline events and receives the stall controls back.
interface reg_scoreboard_if;
    logic       id_valid_i;
    logic       id_wen_i;
    logic [4:0] id_rd_i;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       uses_rs2;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic       kill_valid_i;
    logic [4:0] kill_rd_i;
    logic       flush_i;
    logic       pc_en;
    logic       IF_ID_en;
    logic       ID_EX_flush;
    logic       sb_err_o;
    logic [31:0] stall_cnt_o;

    modport master (
        output id_valid_i, id_wen_i, id_rd_i, rs1_ID, rs2_ID, uses_rs2,
               wb_valid_i, wb_rd_i, kill_valid_i, kill_rd_i, flush_i,
        input  pc_en, IF_ID_en, ID_EX_flush, sb_err_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_wen_i, id_rd_i, rs1_ID, rs2_ID, uses_rs2,
               wb_valid_i, wb_rd_i, kill_valid_i, kill_rd_i, flush_i,
        output pc_en, IF_ID_en, ID_EX_flush, sb_err_o, stall_cnt_o
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: 2-bit pending-write counters for x1..x31 that stall ID on RAW
// hazards, with sticky underflow detection and a saturating stall-cycle counter.
module reg_scoreboard (
    input  logic            clk_i,
    input  logic            rst_i,
    reg_scoreboard_if.slave sb
);
    logic [1:0]  cnt     [32];
    logic [1:0]  cnt_nxt [32];
    logic        underflow;
    logic        hazard;
    logic        stall;
    logic        issue;
    logic        sb_err;
    logic [31:0] stall_cnt;

    // Returns {underflow, new_count}; the net of all same-cycle events is applied at once.
    function automatic logic [2:0] next_count(input logic [1:0] cur, input logic inc,
                                              input logic dec_a, input logic dec_b);
        logic signed [3:0] sum;
        sum = $signed({2'b00, cur}) + $signed({3'b000, inc})
            - $signed({3'b000, dec_a}) - $signed({3'b000, dec_b});
        if (sum < 4'sd0) return {1'b1, 2'd0};
        if (sum > 4'sd3) return {1'b0, 2'd3};
        return {1'b0, sum[1:0]};
    endfunction

    // Hazard looks only at registered counts, so a retiring write never bypasses into ID.
    always_comb begin
        hazard = 1'b0;
        if (sb.id_valid_i) begin
            if (sb.rs1_ID != 5'd0 && cnt[sb.rs1_ID] != 2'd0)
                hazard = 1'b1;
            if (sb.uses_rs2 && sb.rs2_ID != 5'd0 && cnt[sb.rs2_ID] != 2'd0)
                hazard = 1'b1;
            if (sb.id_wen_i && sb.id_rd_i != 5'd0 && cnt[sb.id_rd_i] == 2'd3)
                hazard = 1'b1;
        end
    end

    assign stall          = hazard && !sb.flush_i;
    assign issue          = sb.id_valid_i && sb.id_wen_i && (sb.id_rd_i != 5'd0)
                            && !stall && !sb.flush_i;
    assign sb.pc_en       = !stall;
    assign sb.IF_ID_en    = !stall;
    assign sb.ID_EX_flush = stall || sb.flush_i;
    assign sb.sb_err_o    = sb_err;
    assign sb.stall_cnt_o = stall_cnt;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic [2:0] res;
        underflow  = 1'b0;
        cnt_nxt[0] = 2'd0;
        for (int r = 1; r < 32; r++) begin
            res = next_count(cnt[r],
                             issue && (sb.id_rd_i == 5'(r)),
                             sb.wb_valid_i && (sb.wb_rd_i == 5'(r)),
                             sb.kill_valid_i && (sb.kill_rd_i == 5'(r)));
            cnt_nxt[r] = res[1:0];
            underflow  = underflow | res[2];
        end
    end

    // NOTE: the counter array is reset as a whole; in-flight tracking must vanish on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            for (int r = 0; r < 32; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_err    <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            if (underflow)
                sb_err <= 1'b1;
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hand-computed stall, flush, error and stall-count
// expectations for RAW, rs2 gating, x0, double writes, simultaneous events, limits and async reset.
module tb_reg_scoreboard;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_scoreboard_if sb_bus ();

    reg_scoreboard dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic exp_stall, input logic exp_flush);
        check({tag, ".pc_en"},       32'(sb_bus.pc_en),       32'(!exp_stall));
        check({tag, ".IF_ID_en"},    32'(sb_bus.IF_ID_en),    32'(!exp_stall));
        check({tag, ".ID_EX_flush"}, 32'(sb_bus.ID_EX_flush), 32'(exp_flush));
    endtask

    // Applies one cycle of inputs at the falling edge; checks follow 1 time unit later.
    task automatic drive(input logic v, input logic wen, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic wbv, input logic [4:0] wbrd,
                         input logic kv, input logic [4:0] krd, input logic fl);
        @(negedge clk);
        sb_bus.id_valid_i   = v;
        sb_bus.id_wen_i     = wen;
        sb_bus.id_rd_i      = rd;
        sb_bus.rs1_ID       = rs1;
        sb_bus.rs2_ID       = rs2;
        sb_bus.uses_rs2     = u2;
        sb_bus.wb_valid_i   = wbv;
        sb_bus.wb_rd_i      = wbrd;
        sb_bus.kill_valid_i = kv;
        sb_bus.kill_rd_i    = krd;
        sb_bus.flush_i      = fl;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        drive(1, 1, rd, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read1(input logic [4:0] rs);
        drive(1, 0, 0, rs, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [4:0] rd);
        drive(0, 0, 0, 0, 0, 0, 1, rd, 0, 0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        sb_bus.id_valid_i   = 0; sb_bus.id_wen_i  = 0; sb_bus.id_rd_i   = 0;
        sb_bus.rs1_ID       = 0; sb_bus.rs2_ID    = 0; sb_bus.uses_rs2  = 0;
        sb_bus.wb_valid_i   = 0; sb_bus.wb_rd_i   = 0;
        sb_bus.kill_valid_i = 0; sb_bus.kill_rd_i = 0; sb_bus.flush_i   = 0;
        #2;
        check_ctl("reset", 0, 0);
        check("reset.stall_cnt", sb_bus.stall_cnt_o, 0);
        check("reset.err", 32'(sb_bus.sb_err_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic RAW on x5: three stalled cycles, the last one with the retiring write.
        issue(5);                         check_ctl("raw.issue", 0, 0);
        read1(5);                         check_ctl("raw.stall1", 1, 1);
        read1(5);                         check_ctl("raw.stall2", 1, 1);
        check("raw.cnt1", sb_bus.stall_cnt_o, 1);
        drive(1, 0, 0, 5, 0, 0, 1, 5, 0, 0, 0);
        check_ctl("raw.no_bypass", 1, 1);
        read1(5);                         check_ctl("raw.cleared", 0, 0);
        check("raw.stall_cnt", sb_bus.stall_cnt_o, 3);

        // rs2 is only a hazard when the instruction consumes it.
        issue(7);
        drive(1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0); check_ctl("rs2.unused", 0, 0);
        drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); check_ctl("rs2.used", 1, 1);
        wb(7);
        check("rs2.stall_cnt", sb_bus.stall_cnt_o, 4);

        // x0 is never tracked; retire/kill of x0 must not flag underflow.
        issue(0);                         check_ctl("x0.issue", 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        check_ctl("x0.read", 0, 0);
        issue(3);
        check("x0.err", 32'(sb_bus.sb_err_o), 0);
        issue(3);                         check_ctl("dbl.issue2", 0, 0);
        wb(3);
        read1(3);                         check_ctl("dbl.one_left", 1, 1);
        drive(1, 0, 0, 3, 0, 0, 1, 3, 0, 0, 0);
        check_ctl("dbl.second_wb", 1, 1);
        read1(3);                         check_ctl("dbl.cleared", 0, 0);
        check("dbl.stall_cnt", sb_bus.stall_cnt_o, 6);

        // Issue + wb + kill on x9 with one pending write nets to zero.
        issue(9);
        drive(1, 1, 9, 0, 0, 0, 1, 9, 1, 9, 0);
        check_ctl("sim.issue", 0, 0);
        read1(9);                         check_ctl("sim.net_zero", 0, 0);
        check("sim.err", 32'(sb_bus.sb_err_o), 0);

        // Flush overrides a hazard and suppresses the issue of the discarded instruction.
        issue(10);
        drive(1, 1, 10, 10, 0, 0, 0, 0, 0, 0, 1);
        check_ctl("flush.hazard", 0, 1);
        wb(10);
        read1(10);                        check_ctl("flush.no_issue", 0, 0);
        check("flush.stall_cnt", sb_bus.stall_cnt_o, 6);

        // Saturated counter blocks a fourth write to x4 rather than wrapping.
        issue(4); issue(4); issue(4);     check_ctl("sat.third", 0, 0);
        issue(4);                         check_ctl("sat.block", 1, 1);
        wb(4);
        read1(4);                         check_ctl("sat.two_left", 1, 1);
        wb(4); wb(4);
        read1(4);                         check_ctl("sat.drained", 0, 0);
        check("sat.err", 32'(sb_bus.sb_err_o), 0);
        check("sat.stall_cnt", sb_bus.stall_cnt_o, 8);

        // Underflow on x12 clamps at zero and sets a sticky error.
        wb(12);
        read1(12);                        check_ctl("uf.clamped", 0, 0);
        check("uf.err", 32'(sb_bus.sb_err_o), 1);
        issue(12);
        read1(12);                        check_ctl("uf.counts_from_0", 1, 1);
        wb(12);
        check("uf.err_sticky", 32'(sb_bus.sb_err_o), 1);

        // Async reset between edges with x6 pending.
        issue(6);
        read1(6);                         check_ctl("arst.pre", 1, 1);
        check("arst.pre_cnt", sb_bus.stall_cnt_o, 9);
        #1 rst = 1'b1;
        #1;
        check_ctl("arst.during", 0, 0);
        check("arst.stall_cnt", sb_bus.stall_cnt_o, 0);
        check("arst.err", 32'(sb_bus.sb_err_o), 0);
        #1 rst = 1'b0;
        read1(6);                         check_ctl("arst.after", 0, 0);
        check("arst.cnt_after", sb_bus.stall_cnt_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
